// File: rtl/int_scheduler.sv
// int_scheduler: three-source edge-triggered interrupt scheduler with a small
// memory-mapped register block (ENABLE / PENDING / STATUS) and an
// IDLE -> REQ -> SERVICE handshake with the CPU control unit.
module int_scheduler #(
  parameter logic [31:0] BASE = 32'h4000_0030
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  src_irq,
  input  logic        monin,
  input  logic        irq_ack,
  input  logic        eret,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq_req,
  output logic [1:0]  irq_code
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e      state_q;
  logic [2:0]  src_q;
  logic [2:0]  prev_q;
  logic        arm_q;
  logic [2:0]  en_q, en_d;
  logic [2:0]  pend_q, pend_d;
  logic [1:0]  code_q;
  logic        insvc_q;
  logic        irq_req_q;
  logic [1:0]  irq_code_q;

  logic        sel_en, sel_pend, sel_stat;
  logic [2:0]  edge_set;
  logic [2:0]  w1c_mask;
  logic [2:0]  ack_clr;
  logic [2:0]  code_mask;
  logic [2:0]  pend_en;
  logic [1:0]  prio_code;
  logic        latched_live;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:3];

  assign sel_en   = (addr == BASE);
  assign sel_pend = (addr == BASE + 32'd4);
  assign sel_stat = (addr == BASE + 32'd8);

  assign pend_en  = pend_q & en_q;

  // Priority encode (RX > TX > timer) and one-hot mask of the latched code
  always_comb begin
    prio_code = 2'd0;
    if (pend_en[2])      prio_code = 2'd3;
    else if (pend_en[1]) prio_code = 2'd2;
    else if (pend_en[0]) prio_code = 2'd1;

    code_mask = '0;
    case (code_q)
      2'd1:    code_mask = 3'b001;
      2'd2:    code_mask = 3'b010;
      2'd3:    code_mask = 3'b100;
      default: code_mask = '0;
    endcase
    latched_live = |(pend_en & code_mask);
  end

  // Next-state for pending and enable registers; hardware set wins over clears
  always_comb begin
    edge_set = src_q & ~prev_q;
    w1c_mask = (wr && sel_pend) ? wdata[2:0] : '0;
    ack_clr  = (state_q == REQ && irq_ack) ? code_mask : '0;
    pend_d   = (pend_q & ~w1c_mask & ~ack_clr) | edge_set;
    en_d     = (wr && sel_en) ? wdata[2:0] : en_q;
  end

  // Edge history, enable and pending registers
  // prev_q loads the live input in the first cycle after reset so a level that
  // is already high is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      prev_q <= '0;
      arm_q  <= 1'b0;
      en_q   <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= src_irq;
      prev_q <= arm_q ? src_q : src_irq;
      arm_q  <= 1'b1;
      en_q   <= en_d;
      pend_q <= pend_d;
    end
  end

  // Request/service FSM with registered irq_req/irq_code
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      code_q     <= '0;
      insvc_q    <= 1'b0;
      irq_req_q  <= 1'b0;
      irq_code_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!monin && (pend_en != 3'b000)) begin
            code_q     <= prio_code;
            irq_code_q <= prio_code;
            irq_req_q  <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            insvc_q    <= 1'b1;
            irq_req_q  <= 1'b0;
            irq_code_q <= '0;
            state_q    <= SERVICE;
          end else if (!latched_live) begin
            code_q     <= '0;
            irq_req_q  <= 1'b0;
            irq_code_q <= '0;
            state_q    <= IDLE;
          end
        end
        SERVICE: begin
          if (eret) begin
            insvc_q <= 1'b0;
            code_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          code_q     <= '0;
          insvc_q    <= 1'b0;
          irq_req_q  <= 1'b0;
          irq_code_q <= '0;
        end
      endcase
    end
  end

  // Combinational register read-back
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_en)        rdata[2:0] = en_q;
      else if (sel_pend) rdata[2:0] = pend_q;
      else if (sel_stat) rdata[4:0] = {state_q, insvc_q, code_q};
    end
  end

  assign irq_req  = irq_req_q;
  assign irq_code = irq_code_q;

endmodule

// File: tb/tb_int_scheduler.sv
// Self-checking bench for int_scheduler: directed scenarios followed by a
// randomized run, all checked against a behavioural model of the scheduler.
module tb_int_scheduler;

  localparam logic [31:0] BASE = 32'h4000_0030;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src_irq;
  logic        monin;
  logic        irq_ack;
  logic        eret;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq_req;
  logic [1:0]  irq_code;

  always #5 clk = ~clk;

  int_scheduler #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .monin(monin),
    .irq_ack(irq_ack), .eret(eret), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq_req(irq_req), .irq_code(irq_code)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: state 0 idle, 1 requesting, 2 in service
  int         m_state = 0;
  int         m_code  = 0;
  logic [2:0] m_en    = '0;
  logic [2:0] m_pend  = '0;
  logic [2:0] m_last  = '0;   // src sampled at the previous edge
  logic [2:0] m_prev2 = '0;   // src sampled two edges ago
  int         m_edges = 0;    // edges since reset released

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic rd_v, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    if (rd_v) begin
      if (a == BASE)               v = {29'd0, m_en};
      else if (a == BASE + 32'd4)  v = {29'd0, m_pend};
      else if (a == BASE + 32'd8)  v = {27'd0, m_state[1:0], (m_state == 2), m_code[1:0]};
    end
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    logic [2:0] pe, set_v, ack_clr, w1c;
    int k;
    if (reset) begin
      m_state = 0; m_code = 0; m_en = '0; m_pend = '0;
      m_last = '0; m_prev2 = '0; m_edges = 0;
      return;
    end
    pe = m_pend & m_en;
    ack_clr = '0;
    k = m_edges + 1;
    set_v = (k >= 3) ? (m_last & ~m_prev2) : 3'b000;
    m_prev2 = m_last;
    m_last  = src_irq;
    m_edges = (k > 10) ? 10 : k;
    case (m_state)
      0: if (!monin && pe != 3'b000) begin
           for (int i = 2; i >= 0; i--) begin
             if (pe[i]) begin m_code = i + 1; break; end
           end
           m_state = 1;
         end
      1: if (irq_ack) begin
           ack_clr = 3'(1 << (m_code - 1));
           m_state = 2;
         end else if (pe[m_code - 1] == 1'b0) begin
           m_state = 0; m_code = 0;
         end
      2: if (eret) begin m_state = 0; m_code = 0; end
      default: ;
    endcase
    w1c = (wr && addr == BASE + 32'd4) ? wdata[2:0] : 3'b000;
    m_pend = (m_pend & ~w1c & ~ack_clr) | set_v;
    if (wr && addr == BASE) m_en = wdata[2:0];
  endtask

  // One clock cycle: check bus read, clock both sides, check outputs
  task automatic cycle();
    #1;
    check("rdata", rdata, model_read(rd, addr));
    model_edge();
    @(posedge clk);
    #1;
    check("irq_req", irq_req, (m_state == 1));
    check("irq_code", irq_code, (m_state == 1) ? m_code : 0);
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    check(tag, rdata, exp);
    check({tag, "_model"}, rdata, model_read(1'b1, a));
    rd = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cycle();
    wr = 1'b0;
  endtask

  int exp_codes[3] = '{3, 2, 1};
  logic [31:0] addr_tab[6];

  initial begin
    addr_tab = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE - 32'd4, BASE + 32'd1};
    reset = 1'b1; src_irq = 3'b111; monin = 1'b0; irq_ack = 1'b0; eret = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;

    // Reset with all sources already high; no edge must appear afterwards
    @(posedge clk); #1;
    cycle();
    check("rst_req", irq_req, 1'b0);
    check("rst_code", irq_code, 2'b00);
    peek("rst_status", BASE + 32'd8, 32'h0);
    reset = 1'b0;
    do_write(BASE, 32'h7);
    repeat (3) cycle();
    peek("high_at_reset_pend", BASE + 32'd4, 32'h0);
    check("high_at_reset_req", irq_req, 1'b0);
    src_irq = 3'b000;
    repeat (2) cycle();

    // Single timer interrupt: latency, ack, eret
    do_write(BASE, 32'h1);
    peek("enable_rb", BASE, 32'h1);
    src_irq = 3'b001; cycle();
    src_irq = 3'b000; cycle();
    peek("lat_pend", BASE + 32'd4, 32'h1);
    check("lat_req_early", irq_req, 1'b0);
    cycle();
    check("lat_req", irq_req, 1'b1);
    check("lat_code", irq_code, 2'b01);
    cycle();
    irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    peek("ack_pend", BASE + 32'd4, 32'h0);
    peek("ack_status", BASE + 32'd8, 32'h15);
    check("svc_req", irq_req, 1'b0);
    eret = 1'b1; cycle(); eret = 1'b0;
    peek("eret_status", BASE + 32'd8, 32'h0);

    // Three simultaneous sources serviced in priority order
    do_write(BASE, 32'h7);
    src_irq = 3'b111; cycle();
    src_irq = 3'b000; cycle();
    peek("all_pend", BASE + 32'd4, 32'h7);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("prio_code", irq_code, exp_codes[i]);
      irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
      eret = 1'b1; cycle(); eret = 1'b0;
    end
    peek("prio_done_pend", BASE + 32'd4, 32'h0);

    // Software clears the latched source while requesting
    src_irq = 3'b010; cycle();
    src_irq = 3'b000; cycle();
    cycle();
    check("w1c_req_code", irq_code, 2'b10);
    do_write(BASE + 32'd4, 32'h2);
    cycle();
    check("w1c_drop_req", irq_req, 1'b0);
    peek("w1c_status", BASE + 32'd8, 32'h0);

    // Kernel mode blocks, release raises request one cycle later;
    // W1C and hardware set on the same edge leaves the bit set
    monin = 1'b1;
    src_irq = 3'b001; cycle();
    src_irq = 3'b000; wr = 1'b1; addr = BASE + 32'd4; wdata = 32'h1; cycle(); wr = 1'b0;
    peek("set_wins_w1c", BASE + 32'd4, 32'h1);
    repeat (3) cycle();
    check("monin_block", irq_req, 1'b0);
    monin = 1'b0; cycle();
    check("monin_release", irq_req, 1'b1);
    check("monin_code", irq_code, 2'b01);

    // Ack coincides with a new edge on the same source: bit re-set
    src_irq = 3'b001; cycle();
    src_irq = 3'b000; irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    peek("set_wins_ack", BASE + 32'd4, 32'h1);

    // Reset while in service
    reset = 1'b1; cycle(); reset = 1'b0;
    check("rst_svc_req", irq_req, 1'b0);
    check("rst_svc_code", irq_code, 2'b00);
    peek("rst_svc_status", BASE + 32'd8, 32'h0);
    peek("rst_svc_pend", BASE + 32'd4, 32'h0);
    peek("rst_svc_en", BASE, 32'h0);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      src_irq = src_irq ^ 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      monin   = ($urandom_range(0, 3) == 0);
      irq_ack = (m_state == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      eret    = (m_state == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 199) == 0);
      addr    = addr_tab[$urandom_range(0, 5)];
      rd      = 1'($urandom_range(0, 1));
      wr      = ($urandom_range(0, 3) == 0);
      wdata   = $urandom;
      cycle();
    end
    reset = 1'b0; irq_ack = 1'b0; eret = 1'b0; rd = 1'b0; wr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/int_scheduler.md
INT_SCHEDULER -- requirements
Module: int_scheduler

Interface
REQ-001 SHALL have port clk  input  1  system clock (CPU pipeline clock); all logic on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port src_irq  input  3  raw interrupt levels: bit0 timer, bit1 UART TX done, bit2 UART RX ready.
REQ-004 SHALL have port monin  input  1  CPU kernel-mode flag (PC[31]); 1 blocks new requests.
REQ-005 SHALL have port irq_ack  input  1  one-cycle pulse; CPU has redirected the PC to the interrupt handler.
REQ-006 SHALL have port eret  input  1  one-cycle pulse; the handler has returned.
REQ-007 SHALL have port rd  input  1  bus read strobe.
REQ-008 SHALL have port wr  input  1  bus write strobe.
REQ-009 SHALL have port addr  input  32  bus byte address.
REQ-010 SHALL have port wdata  input  32  bus write data.
REQ-011 SHALL have port rdata  output  32  bus read data; combinational from addr/rd.
REQ-012 SHALL have port irq_req  output  1  interrupt request to the CPU control unit.
REQ-013 SHALL have port irq_code  output  2  latched source code: 01 timer, 10 TX, 11 RX; 00 when irq_req=0.
REQ-014 SHALL have parameter BASE, default 32'h4000_0030, register block base address.

Function
REQ-015 SHALL detect a rising edge per src_irq bit (registered previous value) and set the corresponding pending bit on the following clk edge.
REQ-016 SHALL implement registers ENABLE (BASE+0, bits[2:0] RW), PENDING (BASE+4, bits[2:0], read; write-1-to-clear), STATUS (BASE+8, read-only: bits[1:0] current code, bit2 in_service, bits[4:3] FSM state).
REQ-017 SHALL return 0 on rdata for rd=0 or an unmapped address, and ignore writes to unmapped or read-only addresses; unused bits read 0.
REQ-018 SHALL, when a hardware set and a software W1C hit the same pending bit in the same cycle, leave the bit set.
REQ-019 SHALL implement the FSM states IDLE, REQ, SERVICE.
REQ-020 IDLE: when monin=0 and (PENDING & ENABLE)!=0, SHALL latch the highest-priority source (RX > TX > timer) into the code register and enter REQ on the next edge.
REQ-021 REQ: SHALL drive irq_req=1 and irq_code=latched code every cycle in REQ.
REQ-022 REQ: on irq_ack=1, SHALL clear the latched source's pending bit, set in_service, and enter SERVICE.
REQ-023 REQ: when irq_ack=0 and the latched source's (PENDING & ENABLE) bit has become 0, SHALL drop irq_req and return to IDLE; a new higher-priority source does not pre-empt the latched one.
REQ-024 SERVICE: SHALL hold irq_req=0; on eret=1, SHALL clear in_service and return to IDLE; no nesting is allowed.
REQ-025 SHALL ignore irq_ack outside REQ and eret outside SERVICE.
REQ-026 SHALL give latency: src_irq edge sampled at edge N -> pending at N+1 -> irq_req=1 after N+2 (IDLE, enabled, monin=0).
REQ-027 SHALL, when an edge on the acknowledged source arrives in the same cycle as irq_ack, re-set that pending bit (set wins).

Reset
REQ-028 SHALL, with reset=1 at a clk edge, clear ENABLE, PENDING, edge history, code, and in_service; FSM -> IDLE; irq_req=0, irq_code=00. This SHALL apply from any state, including mid-REQ or mid-SERVICE.
REQ-029 SHALL, in the first cycle after reset, not detect an edge on a src_irq bit that is already high.

Verification
REQ-030 ENABLE=3'b001, timer pulse at edge 10 -> PENDING=001 at 11, irq_req=1 and irq_code=01 from 12; irq_ack at 14 -> PENDING=000, STATUS.in_service=1; eret -> IDLE.
REQ-031 ENABLE=3'b111, all three sources pulse in the same cycle -> code 11 first; after ack and eret -> 10, then -> 01.
REQ-032 In REQ with code 10, software writes 3'b010 to PENDING -> irq_req=0 on the next cycle, FSM back in IDLE.
REQ-033 monin=1 with PENDING&ENABLE=001 -> irq_req stays 0; monin drops to 0 -> irq_req=1 one cycle later.
REQ-034 Timer edge and W1C of bit0 in the same cycle -> PENDING bit0=1; reset asserted in SERVICE -> all outputs 0 and STATUS=0 on the next cycle.
